e_mdu: RTL

//  Multiply/divide unit of the E stage; consumes E-stage register outputs (rs/rt values, decoded op).

---
 rtl/e_mdu_pkg.sv | 26 ++
 rtl/e_mdu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU op codes and default latencies shared by the E-stage multiply/divide unit
package e_mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO; MDU_MADD_EN enables madd/maddu/msub/msubu
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic        o_busy,
    output logic        o_busy_any,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic        r_busy;
    logic [7:0]  r_cnt;
    logic        r_commit;
    logic [63:0] r_pend;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    mdu_op_e     w_op;
    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_launch;
    logic [7:0]  w_cycles;
    logic [63:0] w_res;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;

    assign w_op     = mdu_op_e'(i_op);
    assign w_accept = i_start & ~i_req & ~r_busy;

    assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide via magnitudes so the 0x80000000 / -1 corner needs no special case.
    assign w_div_signed = (w_op == MDU_DIV);
    assign w_div_a      = w_div_signed ? mag32(i_rs) : i_rs;
    assign w_div_b      = w_div_signed ? mag32(i_rt) : i_rt;
    assign w_uq         = (w_div_b == 32'd0) ? 32'd0 : (w_div_a / w_div_b);
    assign w_ur         = (w_div_b == 32'd0) ? 32'd0 : (w_div_a % w_div_b);
    assign w_q          = (w_div_signed && (i_rs[31] ^ i_rt[31])) ? (~w_uq + 32'd1) : w_uq;
    assign w_r          = (w_div_signed && i_rs[31]) ? (~w_ur + 32'd1) : w_ur;

    always_comb begin
        w_launch = 1'b0;
        w_cycles = 8'd0;
        w_res    = 64'd0;
        w_commit = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        case (w_op)
            MDU_MULT: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = w_prod_s;
                w_commit = 1'b1;
            end
            MDU_MULTU: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = w_prod_u;
                w_commit = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                w_launch = 1'b1;
                w_cycles = 8'(DIV_CYCLES);
                w_res    = {w_r, w_q};
                w_commit = (i_rt != 32'd0);
            end
            MDU_MTHI: w_mthi = 1'b1;
            MDU_MTLO: w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = {r_hi, r_lo} + w_prod_s;
                w_commit = 1'b1;
            end
            MDU_MADDU: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = {r_hi, r_lo} + w_prod_u;
                w_commit = 1'b1;
            end
            MDU_MSUB: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = {r_hi, r_lo} - w_prod_s;
                w_commit = 1'b1;
            end
            MDU_MSUBU: begin
                w_launch = 1'b1;
                w_cycles = 8'(MULT_CYCLES);
                w_res    = {r_hi, r_lo} - w_prod_u;
                w_commit = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // The result is computed at launch and only held here until the latency elapses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= 8'd0;
            r_commit <= 1'b0;
            r_pend   <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (r_busy) begin
            if (r_cnt == 8'd1) begin
                r_busy <= 1'b0;
                r_cnt  <= 8'd0;
                if (r_commit) begin
                    r_hi <= r_pend[63:32];
                    r_lo <= r_pend[31:0];
                end
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end else if (w_accept) begin
            if (w_launch) begin
                r_busy   <= 1'b1;
                r_cnt    <= w_cycles;
                r_pend   <= w_res;
                r_commit <= w_commit;
            end
            if (w_mthi) r_hi <= i_rs;
            if (w_mtlo) r_lo <= i_rs;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_any = r_busy | (i_start & ~i_req);
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule
